orientation_math_unit: RTL and testbench

ORIENTATION_MATH_UNIT -- requirements
Module: orientation_math

---
 rtl/orientation_math_unit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_orientation_math_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/orientation_math_unit.sv
// -----------------------------------------------------------------------------
// orientation_math_unit
//
// Computes the heading, in 15-degree units (0..23), of the vector that runs
// from an original polar point to a final polar point. Both points arrive as
// {theta_index[3:0], radius[7:0]} with angle = index*15 deg. The work is a
// fixed-latency pipeline walked by a small FSM: capture, polar-to-cartesian
// via a sin/cos lookup, difference, then a divider-free sector search that
// compares cross products against 7.5-deg-offset boundary constants.
//
// Ports
//   clock             in   1   rising-edge system clock
//   reset             in   1   asynchronous, active-high
//   r_theta_original  in  12   start point {theta index, radius}
//   r_theta_final     in  12   end point, same format
//   enable            in   1   start request (honoured in IDLE and DONE only)
//   done              out  1   high while orientation is valid
//   orientation       out  5   heading in 15-deg units, 0..23
//
// State table
//   state    | meaning
//   IDLE     | waiting for enable after reset
//   CAPTURE  | registering both input points on the next edge
//   CONVERT  | polar to cartesian products
//   DIFF     | dx/dy of final minus original
//   ANGLE    | sector search, padded so done lands 8 edges after enable
//   DONE     | result valid and held until the next enable
// -----------------------------------------------------------------------------
module orientation_math_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] r_theta_original,
  input  logic [11:0] r_theta_final,
  input  logic        enable,
  output logic        done,
  output logic [4:0]  orientation
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CONVERT = 3'd2,
    S_DIFF    = 3'd3,
    S_ANGLE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Edges spent in ANGLE before entering DONE; with CAPTURE, CONVERT and DIFF
  // this places the DONE entry exactly on the 8th edge after enable.
  localparam logic [2:0] ANGLE_PAD = 3'd4;

  state_t             state_q, state_d;
  logic [11:0]        orig_q, orig_d;
  logic [11:0]        fin_q, fin_d;
  logic signed [20:0] x_o_q, x_o_d;
  logic signed [20:0] y_o_q, y_o_d;
  logic signed [20:0] x_f_q, x_f_d;
  logic signed [20:0] y_f_q, y_f_d;
  logic signed [21:0] dx_q, dx_d;
  logic signed [21:0] dy_q, dy_d;
  logic [2:0]         pad_q, pad_d;
  logic [4:0]         orientation_q, orientation_d;
  logic               done_q, done_d;

  // ---------------------------------------------------------------------------
  // Lookup helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] clamp_theta(input logic [3:0] t);
    return (t > 4'd11) ? 4'd11 : t;
  endfunction

  // cos(index*15 deg) * 1024
  function automatic logic signed [11:0] cos_lut(input logic [3:0] t);
    logic signed [11:0] v;
    case (t)
      4'd0:    v = 12'sd1024;
      4'd1:    v = 12'sd989;
      4'd2:    v = 12'sd887;
      4'd3:    v = 12'sd724;
      4'd4:    v = 12'sd512;
      4'd5:    v = 12'sd265;
      4'd6:    v = 12'sd0;
      4'd7:    v = -12'sd265;
      4'd8:    v = -12'sd512;
      4'd9:    v = -12'sd724;
      4'd10:   v = -12'sd887;
      default: v = -12'sd989;
    endcase
    return v;
  endfunction

  // sin(index*15 deg) * 1024; non-negative over 0..165 deg
  function automatic logic signed [11:0] sin_lut(input logic [3:0] t);
    logic signed [11:0] v;
    case (t)
      4'd0:    v = 12'sd0;
      4'd1:    v = 12'sd265;
      4'd2:    v = 12'sd512;
      4'd3:    v = 12'sd724;
      4'd4:    v = 12'sd887;
      4'd5:    v = 12'sd989;
      4'd6:    v = 12'sd1024;
      4'd7:    v = 12'sd989;
      4'd8:    v = 12'sd887;
      4'd9:    v = 12'sd724;
      4'd10:   v = 12'sd512;
      default: v = 12'sd265;
    endcase
    return v;
  endfunction

  // Sector boundaries inside one quadrant at 7.5 + 15*i deg, scaled by 1024.
  function automatic logic [9:0] bnd_cos(input logic [2:0] i);
    logic [9:0] v;
    case (i)
      3'd0:    v = 10'd1015;
      3'd1:    v = 10'd946;
      3'd2:    v = 10'd812;
      3'd3:    v = 10'd623;
      3'd4:    v = 10'd392;
      default: v = 10'd134;
    endcase
    return v;
  endfunction

  function automatic logic [9:0] bnd_sin(input logic [2:0] i);
    logic [9:0] v;
    case (i)
      3'd0:    v = 10'd134;
      3'd1:    v = 10'd392;
      3'd2:    v = 10'd623;
      3'd3:    v = 10'd812;
      3'd4:    v = 10'd946;
      default: v = 10'd1015;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Cartesian conversion from the captured points
  // ---------------------------------------------------------------------------
  logic [3:0]         th_o, th_f;
  logic signed [8:0]  r_o_s, r_f_s;

  always_comb begin
    th_o  = clamp_theta(orig_q[11:8]);
    th_f  = clamp_theta(fin_q[11:8]);
    r_o_s = signed'({1'b0, orig_q[7:0]});
    r_f_s = signed'({1'b0, fin_q[7:0]});
  end

  // ---------------------------------------------------------------------------
  // Sector search
  //   phi = atan(|dy|/|dx|) is the angle inside the quadrant. k_ge counts
  //   boundaries with phi >= b, k_gt those with phi > b. Quadrants where the
  //   heading grows with phi use k_ge, mirrored quadrants use k_gt, so an
  //   exact tie always lands in the higher heading sector.
  // ---------------------------------------------------------------------------
  logic [21:0] adx, ady;
  logic [31:0] cmp_lhs, cmp_rhs;
  logic [2:0]  k_ge, k_gt;
  logic [4:0]  sector;
  logic [4:0]  shortcut;
  logic        same_theta;
  logic [4:0]  result;

  always_comb begin
    adx     = dx_q[21] ? -dx_q : dx_q;
    ady     = dy_q[21] ? -dy_q : dy_q;
    cmp_lhs = '0;
    cmp_rhs = '0;
    k_ge    = '0;
    k_gt    = '0;
    for (int i = 0; i < 6; i++) begin
      cmp_lhs = 32'(ady) * 32'(bnd_cos(3'(i)));
      cmp_rhs = 32'(adx) * 32'(bnd_sin(3'(i)));
      if (cmp_lhs >= cmp_rhs) k_ge = k_ge + 3'd1;
      if (cmp_lhs >  cmp_rhs) k_gt = k_gt + 3'd1;
    end

    case ({dy_q[21], dx_q[21]})
      2'b00:   sector = {2'b00, k_ge};                     // 0..90 deg
      2'b01:   sector = 5'd12 - {2'b00, k_gt};             // 90..180 deg
      2'b11:   sector = 5'd12 + {2'b00, k_ge};             // 180..270 deg
      default: sector = (k_gt == 3'd0) ? 5'd0 : 5'd24 - {2'b00, k_gt};
    endcase
    // Two distinct angles at radius 0 give no displacement; report 0.
    if ((dx_q == '0) && (dy_q == '0)) sector = 5'd0;

    same_theta = (th_o == th_f);
    shortcut   = (fin_q[7:0] >= orig_q[7:0]) ? {1'b0, th_o}
                                             : {1'b0, th_o} + 5'd12;
    result     = same_theta ? shortcut : sector;
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    orig_d        = orig_q;
    fin_d         = fin_q;
    x_o_d         = x_o_q;
    y_o_d         = y_o_q;
    x_f_d         = x_f_q;
    y_f_d         = y_f_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    pad_d         = pad_q;
    orientation_d = orientation_q;
    done_d        = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (enable) begin
          state_d = S_CAPTURE;
          done_d  = 1'b0;
        end
      end
      S_CAPTURE: begin
        orig_d  = r_theta_original;
        fin_d   = r_theta_final;
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        x_o_d   = 21'(r_o_s) * 21'(cos_lut(th_o));
        y_o_d   = 21'(r_o_s) * 21'(sin_lut(th_o));
        x_f_d   = 21'(r_f_s) * 21'(cos_lut(th_f));
        y_f_d   = 21'(r_f_s) * 21'(sin_lut(th_f));
        state_d = S_DIFF;
      end
      S_DIFF: begin
        dx_d    = 22'(x_f_q) - 22'(x_o_q);
        dy_d    = 22'(y_f_q) - 22'(y_o_q);
        pad_d   = ANGLE_PAD;
        state_d = S_ANGLE;
      end
      S_ANGLE: begin
        if (pad_q == 3'd0) begin
          orientation_d = result;
          done_d        = 1'b1;
          state_d       = S_DONE;
        end else begin
          pad_d = pad_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      orig_q        <= '0;
      fin_q         <= '0;
      x_o_q         <= '0;
      y_o_q         <= '0;
      x_f_q         <= '0;
      y_f_q         <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      pad_q         <= '0;
      orientation_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      orig_q        <= orig_d;
      fin_q         <= fin_d;
      x_o_q         <= x_o_d;
      y_o_q         <= y_o_d;
      x_f_q         <= x_f_d;
      y_f_q         <= y_f_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      pad_q         <= pad_d;
      orientation_q <= orientation_d;
      done_q        <= done_d;
    end
  end

  assign done        = done_q;
  assign orientation = orientation_q;

endmodule

// File: tb/tb_orientation_math_unit.sv
// -----------------------------------------------------------------------------
// tb_orientation_math_unit
//
// Directed bench for orientation_math_unit. Each operation checks that done
// drops on acceptance, is still low after 7 edges, and is high with the
// hand-computed heading after the 8th edge. Outputs are sampled 1 time unit
// after the rising edge; inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_orientation_math_unit;

  logic        clock;
  logic        reset;
  logic [11:0] r_theta_original;
  logic [11:0] r_theta_final;
  logic        enable;
  logic        done;
  logic [4:0]  orientation;

  int checks;
  int failures;

  orientation_math_unit dut (
    .clock            (clock),
    .reset            (reset),
    .r_theta_original (r_theta_original),
    .r_theta_final    (r_theta_final),
    .enable           (enable),
    .done             (done),
    .orientation      (orientation)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Presents one request; returns just after the edge that sampled enable.
  task automatic start_op(input logic [11:0] orig, input logic [11:0] fin);
    r_theta_original = orig;
    r_theta_final    = fin;
    enable           = 1'b1;
    step(1);
    enable           = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [11:0] orig,
                        input logic [11:0] fin, input logic [4:0] exp);
    start_op(orig, fin);
    check({tag, "_accept_done"}, {31'd0, done}, 32'd0);
    step(7);
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    step(1);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_orient"}, {27'd0, orientation}, {27'd0, exp});
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    enable           = 1'b0;
    r_theta_original = '0;
    r_theta_final    = '0;

    step(3);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_orient", {27'd0, orientation}, 32'd0);
    reset = 1'b0;

    // Accepted on the first edge after reset release.
    run_op("v1", 12'h13A, 12'h343, 5'd7);
    step(5);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_orient", {27'd0, orientation}, 32'd7);

    // Restart from DONE: done clears, old heading stays until DONE re-entry.
    start_op(12'h395, 12'h556);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_orient", {27'd0, orientation}, 32'd7);
    step(7);
    check("v2_done_early", {31'd0, done}, 32'd0);
    step(1);
    check("v2_done", {31'd0, done}, 32'd1);
    check("v2_orient", {27'd0, orientation}, 32'd13);

    run_op("v3", 12'h52C, 12'h13C, 5'd22);
    run_op("v4", 12'h122, 12'h35D, 5'd4);
    run_op("v5_tie45", 12'hB25, 12'h725, 5'd3);

    run_op("sc_grow", 12'h110, 12'h115, 5'd1);
    run_op("sc_shrink", 12'h110, 12'h105, 5'd13);
    run_op("sc_same", 12'h320, 12'h320, 5'd3);
    run_op("sc_clamp", 12'hF20, 12'hC30, 5'd11);
    run_op("sc_clamp_back", 12'hD40, 12'hB10, 5'd23);

    // Near-axis vectors: dx=37634, dy=-14 sits just under 360 deg -> 0;
    // dx=-4, dy=140452 sits just past 90 deg -> 6.
    run_op("near_x", 12'h50B, 12'h129, 5'd0);
    run_op("near_y", 12'h129, 12'h599, 5'd6);

    // Exact axis vectors built from radius-0 endpoints.
    run_op("axis_px", 12'h600, 12'h010, 5'd0);
    run_op("axis_py", 12'h000, 12'h610, 5'd6);
    run_op("axis_nx", 12'h010, 12'h600, 5'd12);
    run_op("axis_ny", 12'h610, 12'h000, 5'd18);
    // Index 14 must act as 165 deg: heading 165 deg -> 11.
    run_op("clamp_vec", 12'h000, 12'hE40, 5'd11);

    // enable while busy is ignored.
    start_op(12'h13A, 12'h343);
    step(3);
    r_theta_original = 12'h395;
    r_theta_final    = 12'h556;
    enable           = 1'b1;
    step(1);
    enable           = 1'b0;
    step(3);
    check("busy_done_early", {31'd0, done}, 32'd0);
    step(1);
    check("busy_done", {31'd0, done}, 32'd1);
    check("busy_orient", {27'd0, orientation}, 32'd7);
    step(6);
    check("busy_hold_done", {31'd0, done}, 32'd1);
    check("busy_hold_orient", {27'd0, orientation}, 32'd7);

    // Reset in the middle of a computation.
    start_op(12'h395, 12'h556);
    step(3);
    reset = 1'b1;
    step(1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_orient", {27'd0, orientation}, 32'd0);
    reset = 1'b0;
    step(12);
    check("midrst_no_done", {31'd0, done}, 32'd0);
    check("midrst_no_orient", {27'd0, orientation}, 32'd0);
    run_op("after_rst", 12'h52C, 12'h13C, 5'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
